// File: rtl/pixel_stream_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_tx_if
// Brief    : Pixel-memory read port and valid/ready pixel stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_stream_tx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_valid;
  logic                  pix_ready;
  logic                  pix_sof;
  logic                  pix_eol;
  logic                  pix_eof;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_data,
    output pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    input  pix_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_data,
    input  pix_data, pix_valid, pix_sof, pix_eol, pix_eof,
    output pix_ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : pixel_stream_tx
// Brief    : Reads one image from pixel memory in raster order and streams it
//            out with SOF/EOL/EOF markers through a 2-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_stream_tx #(
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  wire               clk,
  input  wire               rst,
  input  wire               start,
  output logic              busy,
  output logic              done,
  pixel_stream_tx_if.master bus
);
  localparam int c_XW = $clog2(IMG_WIDTH);
  localparam int c_YW = $clog2(IMG_HEIGHT);
  localparam logic [c_XW-1:0]       c_X_LAST    = c_XW'(IMG_WIDTH - 1);
  localparam logic [c_YW-1:0]       c_Y_LAST    = c_YW'(IMG_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_pend;
  logic [c_XW-1:0]       r_x;
  logic [c_YW-1:0]       r_y;
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [2:0]            r_fifo_mark [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [2:0]            w_level;
  logic [2:0]            w_head_mark;

  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = w_valid & bus.pix_ready;
  assign w_head_mark = r_fifo_mark[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Slots committed after this edge; counting the pop keeps reads flowing at one per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_level     = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_pop};
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        busy    = 1'b1;
        w_rd_en = (w_level < 3'd2);
        if (w_rd_en && (r_addr == c_ADDR_LAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_pop && w_head_mark[0]) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr         <= '0;
      r_pend         <= 1'b0;
      r_x            <= '0;
      r_y            <= '0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_mark[0] <= '0;
      r_fifo_mark[1] <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_count        <= '0;
    end else begin
      r_pend <= w_rd_en;
      if ((r_state == S_IDLE) && start) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else begin
        // Address parks on the last pixel once the frame has been fully requested.
        if (w_rd_en && (r_addr != c_ADDR_LAST)) r_addr <= r_addr + 1'b1;
        if (r_pend) begin
          if (r_x == c_X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
      end
      if (r_pend) begin
        r_fifo_data[r_wptr] <= bus.mem_data;
        r_fifo_mark[r_wptr] <= {(r_x == '0) && (r_y == '0),
                                (r_x == c_X_LAST),
                                (r_x == c_X_LAST) && (r_y == c_Y_LAST)};
        r_wptr              <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  assign bus.mem_rd_en = w_rd_en;
  assign bus.mem_addr  = r_addr;
  assign bus.pix_valid = w_valid;
  assign bus.pix_data  = w_valid ? r_fifo_data[r_rptr] : '0;
  assign bus.pix_sof   = w_valid & w_head_mark[2];
  assign bus.pix_eol   = w_valid & w_head_mark[1];
  assign bus.pix_eof   = w_valid & w_head_mark[0];
endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_stream_tx
// Brief    : Directed self-checking bench for pixel_stream_tx (4x3 and 220x220).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_stream_tx;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic start_b;
  logic busy_b;
  logic done_b;
  int   n_checks = 0;
  int   n_fail   = 0;

  pixel_stream_tx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_s ();
  pixel_stream_tx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus_b ();

  pixel_stream_tx #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus_s.master)
  );

  pixel_stream_tx #(.IMG_WIDTH(220), .IMG_HEIGHT(220), .DATA_WIDTH(8), .ADDR_WIDTH(16)) u_big (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .bus(bus_b.master)
  );

  always #5 clk = ~clk;

  // Pixel memory holds value = address (low byte), one-cycle read latency.
  always @(posedge clk) begin
    if (bus_s.mem_rd_en) bus_s.mem_data <= bus_s.mem_addr[7:0];
    if (bus_b.mem_rd_en) bus_b.mem_data <= bus_b.mem_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs_s();
    return {1'b0, busy, done, bus_s.mem_rd_en, bus_s.mem_addr, bus_s.pix_data,
            bus_s.pix_valid, bus_s.pix_sof, bus_s.pix_eol, bus_s.pix_eof};
  endfunction

  // Starts a frame on the next edge and follows it until done; stall selects 1-high/2-low ready.
  task automatic run_frame(input bit stall, input int p1, input int p2);
    int         e;
    int         issued;
    bit         seen_done;
    bit         pv;
    bit         pr;
    logic [7:0] pd;
    logic [2:0] pm;
    logic [2:0] m;
    e = 0; issued = 0; seen_done = 0; pv = 0; pr = 0; pd = '0; pm = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 200 && !seen_done; k++) begin
      @(negedge clk);
      bus_s.pix_ready = stall ? ((k % 3) == 0) : 1'b1;
      start = (k == p1) || (k == p2);
      #1;
      m = {bus_s.pix_sof, bus_s.pix_eol, bus_s.pix_eof};
      if (k == 1) begin
        check("busy_c1", busy, 1);
        check("rd_en_c1", bus_s.mem_rd_en, 1);
      end
      if (pv && !pr) begin
        check("stall_valid", bus_s.pix_valid, 1);
        check("stall_data", bus_s.pix_data, pd);
        check("stall_mark", m, pm);
      end
      if (!bus_s.pix_valid) check("mark_idle", m, 0);
      if (bus_s.mem_rd_en) begin
        check("rd_addr", bus_s.mem_addr, issued);
        issued++;
      end
      if (bus_s.pix_valid && bus_s.pix_ready) begin
        check("px_data", bus_s.pix_data, e);
        check("px_mark", m, {e == 0, (e % W) == W - 1, e == N - 1});
        if (!stall) check("px_cycle", k, e + 3);
        e++;
      end
      check("outstanding_le2", (issued - e) <= 2, 1);
      if (done) begin
        seen_done = 1;
        check("done_npix", e, N);
        check("done_busy", busy, 0);
        if (!stall) check("done_cycle", k, N + 3);
      end
      pv = bus_s.pix_valid; pr = bus_s.pix_ready; pd = bus_s.pix_data; pm = m;
    end
    start = 1'b0;
    check("frame_done_seen", seen_done, 1);
  endtask

  initial begin
    int  hs;
    int  eols;
    int  bad;
    int  dcyc;
    bit  found;
    rst = 1'b1; start = 1'b0; start_b = 1'b0;
    bus_s.pix_ready = 1'b0; bus_b.pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("reset_outputs", outs_s(), 0);
    check("reset_done_big", {busy_b, done_b, bus_b.pix_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Full-rate frame, then stalled frame
    run_frame(0, 0, 0);
    @(negedge clk); #1;
    run_frame(1, 0, 0);
    bus_s.pix_ready = 1'b1;
    @(negedge clk); #1;

    // start pulses mid-frame must be dropped
    run_frame(0, 5, 9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("post_frame_quiet", {busy, done}, 0);
    end

    // start during DONE is ignored; held into IDLE it launches the next frame
    run_frame(0, 0, 0);
    start = 1'b1;
    @(negedge clk); #1;
    check("start_in_done_ignored", busy, 0);
    run_frame(0, 0, 0);
    @(negedge clk); #1;

    // Asynchronous reset while pixel 6 is presented
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); #1;
      if (bus_s.pix_valid && bus_s.pix_data == 8'd6) found = 1;
    end
    check("rst_px6_seen", found, 1);
    rst = 1'b1;
    #1 check("rst_mid_outputs", outs_s(), 0);
    @(negedge clk); #1;
    check("rst_hold_outputs", outs_s(), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("post_rst_idle", {busy, bus_s.mem_rd_en, bus_s.pix_valid}, 0);
    end
    run_frame(0, 0, 0);

    // Default-size frame at full rate
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    hs = 0; eols = 0; bad = 0; dcyc = 0;
    for (int k = 1; k <= 49000 && dcyc == 0; k++) begin
      @(negedge clk); #1;
      if (bus_b.pix_valid && bus_b.pix_ready) begin
        if (bus_b.pix_data != hs[7:0]) bad++;
        if (bus_b.pix_eol) eols++;
        hs++;
      end
      if (done_b) dcyc = k;
    end
    check("big_handshakes", hs, 48400);
    check("big_eol_count", eols, 220);
    check("big_data_errors", bad, 0);
    check("big_done_cycle", dcyc, 48403);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/pixel_stream_tx.md
# pixel_stream_tx

Frame source for the convolution datapath. On `start`, reads one `IMG_WIDTH` x `IMG_HEIGHT` image from a synchronous-read pixel memory in raster order. It then emits the image as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers. It drives the pixel-valid input of the window-position counter and line buffers, and absorbs downstream backpressure with a 2-entry output buffer.

## Interface
- `IMG_WIDTH`, 220, pixels per line, ≥ 2
- `IMG_HEIGHT`, 220, lines per frame, ≥ 2
- `DATA_WIDTH`, 8, pixel width in bits
- `ADDR_WIDTH`, 16, memory address width, must satisfy 2^ADDR_WIDTH ≥ IMG_WIDTH*IMG_HEIGHT
- One clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `start` in 1: frame request, sampled only in IDLE
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse after the last pixel handshake
- `mem_rd_en` out 1: memory read strobe
- `mem_addr` out ADDR_WIDTH: read address, linear index y*IMG_WIDTH+x
- `mem_data` in DATA_WIDTH: read data, valid the cycle after `mem_rd_en`
- `pix_data` out DATA_WIDTH: stream pixel
- `pix_valid` out 1: stream valid
- `pix_ready` in 1: downstream accept
- `pix_sof` out 1: qualifies pixel (0,0)
- `pix_eol` out 1: qualifies x = IMG_WIDTH-1
- `pix_eof` out 1: qualifies the last pixel of the frame

## Operation
- States:
  - IDLE: `start` = 1 → STREAM; `start` = 0 → stay.
  - STREAM: issue reads. When the last read has been issued → DRAIN.
  - DRAIN: wait until the last pixel is handshaken → DONE.
  - DONE: one cycle, then → IDLE.
- Read issue: `mem_rd_en` = 1 in a cycle when state is STREAM and (buffer occupancy + reads in flight) < 2. `mem_addr` increments by 1 per issued read, from 0 to IMG_WIDTH*IMG_HEIGHT-1.
- Returned `mem_data` is written into the 2-entry FIFO together with its markers, computed from the read-side x/y counters.
  - x wraps at IMG_WIDTH-1 to 0 and increments y.
  - y wraps to 0 at frame end.
- FIFO head drives `pix_data`, `pix_valid` and the marker outputs. A handshake is `pix_valid` & `pix_ready` at a rising edge; it pops the head.
- AXI-stream rules:
  - While `pix_valid` = 1 and `pix_ready` = 0, `pix_data` and all markers hold stable.
  - `pix_valid` never drops without a handshake.
  - `pix_valid` does not depend combinationally on `pix_ready`.
- Markers are 0 whenever `pix_valid` = 0.
- `start` while `busy` = 1 is ignored; there is no queuing.
- Back-to-back frames: `start` high in the cycle `done` pulses is not accepted, because the state is still DONE. It is accepted on the following cycle in IDLE.
- `rst` asserted at any time has immediate effect:
  - State → IDLE.
  - FIFO emptied, in-flight read discarded, counters and address cleared.
  - All outputs 0.
  - The stream resumes only on a new `start`.

## Timing
- Reset value of every output is 0: `busy`, `done`, `mem_rd_en`, `mem_addr`, `pix_data`, `pix_valid`, `pix_sof`, `pix_eol`, `pix_eof`.
- With `start` accepted at edge 0:
  - `busy` = 1 and first `mem_rd_en` (addr 0) are in cycle 1.
  - First `pix_valid` is in cycle 3: read latency 1 + FIFO write 1.
- With `pix_ready` held at 1, there is one pixel per cycle and no bubbles. Let N = IMG_WIDTH*IMG_HEIGHT:
  - Last read in cycle N.
  - Last pixel in cycle N+2.
  - `done` = 1 and `busy` = 0 in cycle N+3.
- Throughput under backpressure: after `pix_ready` deasserts, at most 2 further pixels are buffered, so reads stop within 2 cycles. After `pix_ready` reasserts, `mem_rd_en` re-asserts in the same cycle that a pop frees space.
- `mem_addr` holds its last value while `mem_rd_en` = 0.

## Test plan
- Frame with W=4, H=3, `pix_ready` = 1, memory holding value = address:
  - Pixels 0..11 appear in cycles 3..14.
  - `pix_sof` only on 0; `pix_eol` on 3, 7 and 11; `pix_eof` only on 11.
  - `done` in cycle 15.
- Same frame with `pix_ready` toggling in a 1-high/2-low pattern:
  - Sequence 0..11 intact, with no drops or duplicates.
  - Outputs stable during stalls.
  - Never more than 2 reads outstanding plus buffered.
- `start` pulsed in cycles 5 and 9 during a frame → ignored; exactly 12 pixels and a single `done` pulse.
- `rst` asserted at pixel 6 for 1 cycle, then `start`:
  - All outputs are 0 during reset.
  - The new frame begins at address 0 with `pix_sof`; no stale pixel 6 or 7 appears.
- Two frames, with `start` asserted the cycle after `done` → second frame's `pix_sof` 3 cycles later; both frames are complete and correctly marked.
- Default 220x220 with `pix_ready` = 1:
  - 48400 handshakes.
  - `done` exactly 48403 cycles after `start` acceptance.
  - Count of `pix_eol` = 220.
